// File: rtl/lift_ctrl.sv
// SCAN lift car controller: serves latched floor requests, sweeping one direction
// while requests remain ahead, and returns one-hot clears while the door is open.
module lift_ctrl #(
    parameter int NFLOORS    = 4,
    parameter int MOVE_TICKS = 8,
    parameter int DOOR_TICKS = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       slowref,
    input  logic [NFLOORS-1:0]         flreq,
    output logic [NFLOORS-1:0]         clr_flreq,
    output logic [$clog2(NFLOORS)-1:0] floor_pos,
    output logic                       dir_up,
    output logic                       moving,
    output logic                       door_open
);

    localparam int PW   = $clog2(NFLOORS);
    localparam int MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int CW   = ($clog2(MAXT) > 0) ? $clog2(MAXT) : 1;

    localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
    localparam logic [PW-1:0] TOP_FLOOR = PW'(NFLOORS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NFLOORS-1:0]  clr_q, clr_d;
    logic                moving_q, moving_d;
    logic                door_q, door_d;

    // Any request strictly beyond floor p in the given direction.
    function automatic logic req_beyond(input logic [NFLOORS-1:0] req,
                                        input logic [PW-1:0] p,
                                        input logic up);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NFLOORS; k++) begin
            if (up ? (k > int'(p)) : (k < int'(p))) begin
                r = r | req[k];
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        clr_d    = '0;
        moving_d = 1'b0;
        door_d   = 1'b0;

        if (slowref) begin
            case (state_q)
                IDLE: begin
                    if (flreq[pos_q]) begin
                        state_d = DOOR;
                        cnt_d   = '0;
                    end else if (req_beyond(flreq, pos_q, dir_q)) begin
                        state_d = MOVING;
                    end else if (req_beyond(flreq, pos_q, ~dir_q)) begin
                        state_d = MOVING;
                        dir_d   = ~dir_q;
                    end
                end
                MOVING: begin
                    if (cnt_q == MOVE_LAST) begin
                        cnt_d = '0;
                        // Edge floors cannot be left further; fall back to IDLE in place.
                        if (dir_q ? (pos_q == TOP_FLOOR) : (pos_q == '0)) begin
                            state_d = IDLE;
                        end else begin
                            pos_d = dir_q ? (pos_q + PW'(1)) : (pos_q - PW'(1));
                            if (flreq[pos_d]) begin
                                state_d = DOOR;
                            end else if (req_beyond(flreq, pos_d, dir_q)) begin
                                state_d = MOVING;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DOOR: begin
                    if (cnt_q == DOOR_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        if (state_d == DOOR) begin
            clr_d[pos_d] = 1'b1;
        end
        moving_d = (state_d == MOVING);
        door_d   = (state_d == DOOR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            cnt_q    <= '0;
            clr_q    <= '0;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            clr_q    <= clr_d;
            moving_q <= moving_d;
            door_q   <= door_d;
        end
    end

    assign clr_flreq = clr_q;
    assign floor_pos = pos_q;
    assign dir_up    = dir_q;
    assign moving    = moving_q;
    assign door_open = door_q;

endmodule
